// File: rtl/crank_wheel_gen.sv
// ---------------------------------------------------------------------------
// crank_wheel_gen
//
// Synthesises a toothed crank wheel (default 60-2) with a programmable tooth
// period. It drives bench stimulus or loops back into the crank-capture
// receiver. Each revolution has TEETH slots. The last MISSING slots carry no
// tooth, which gives the receiver its long synchronisation gap.
//
// Ports
//   clk         in   1          single clock, rising edge
//   rst         in   1          asynchronous reset, active low
//   ena         in   1          run enable (level)
//   period      in   PER_WIDTH  slot length in clk cycles, clamped to >= 4
//   inv         in   1          output polarity (1 = tooth drives low)
//   cap_out     out  1          generated wheel signal
//   tooth_num   out  TN_WIDTH   current slot index (0 while idle)
//   gap         out  1          current slot is a missing tooth
//   rev_strobe  out  1          first cycle of slot 0
//   running     out  1          generator is in RUN
//
// All outputs are registered. They present the counter state one cycle after
// that state is entered. As a result, the first output cycle of a run shows
// slot 0 / phase 0 together with rev_strobe.
// ---------------------------------------------------------------------------
module crank_wheel_gen #(
    parameter int TEETH     = 60,
    parameter int MISSING   = 2,
    parameter int PER_WIDTH = 24,
    parameter int TN_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [PER_WIDTH-1:0] period,
    input  logic                 inv,
    output logic                 cap_out,
    output logic [TN_WIDTH-1:0]  tooth_num,
    output logic                 gap,
    output logic                 rev_strobe,
    output logic                 running
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [TN_WIDTH-1:0]  LAST_SLOT = TN_WIDTH'(TEETH - 1);
    localparam logic [TN_WIDTH-1:0]  FIRST_GAP = TN_WIDTH'(TEETH - MISSING);
    localparam logic [PER_WIDTH-1:0] MIN_PER   = PER_WIDTH'(4);

    state_t                 state_q, state_d;
    logic [TN_WIDTH-1:0]    slot_q, slot_d;
    logic [PER_WIDTH-1:0]   phase_q, phase_d;
    logic [PER_WIDTH-1:0]   per_q, per_d;

    logic                   cap_out_q, cap_out_d;
    logic [TN_WIDTH-1:0]    tooth_num_q, tooth_num_d;
    logic                   gap_q, gap_d;
    logic                   rev_strobe_q, rev_strobe_d;
    logic                   running_q, running_d;

    logic [PER_WIDTH-1:0]   per_clamp_s;
    logic                   slot_end_s;
    logic                   tooth_s;

    // Clamp the requested period so that per_q - 1 can never underflow
    always_comb begin
        if (period < MIN_PER) begin
            per_clamp_s = MIN_PER;
        end else begin
            per_clamp_s = period;
        end
    end

    // Next-state logic for the run FSM and the slot/phase counters
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        phase_d    = phase_q;
        per_d      = per_q;
        slot_end_s = (phase_q == (per_q - PER_WIDTH'(1)));
        case (state_q)
            ST_IDLE: begin
                slot_d  = TN_WIDTH'(0);
                phase_d = PER_WIDTH'(0);
                if (ena) begin
                    state_d = ST_RUN;
                    per_d   = per_clamp_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Dropping ena wins over a slot wrap, so no strobe leaks out
                if (!ena) begin
                    state_d = ST_IDLE;
                    slot_d  = TN_WIDTH'(0);
                    phase_d = PER_WIDTH'(0);
                end else if (slot_end_s) begin
                    phase_d = PER_WIDTH'(0);
                    per_d   = per_clamp_s;
                    if (slot_q == LAST_SLOT) begin
                        slot_d = TN_WIDTH'(0);
                    end else begin
                        slot_d = slot_q + TN_WIDTH'(1);
                    end
                end else begin
                    phase_d = phase_q + PER_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = TN_WIDTH'(0);
                phase_d = PER_WIDTH'(0);
                per_d   = MIN_PER;
            end
        endcase
    end

    // Output decode from the current counter state
    always_comb begin
        // Real teeth are high for the first half; odd periods lengthen the low half
        tooth_s = (slot_q < FIRST_GAP) && (phase_q < (per_q >> 1));
        if (state_q == ST_RUN) begin
            cap_out_d    = tooth_s ^ inv;
            tooth_num_d  = slot_q;
            gap_d        = (slot_q >= FIRST_GAP);
            rev_strobe_d = (slot_q == TN_WIDTH'(0)) && (phase_q == PER_WIDTH'(0));
            running_d    = 1'b1;
        end else begin
            cap_out_d    = inv;
            tooth_num_d  = TN_WIDTH'(0);
            gap_d        = 1'b0;
            rev_strobe_d = 1'b0;
            running_d    = 1'b0;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            slot_q       <= TN_WIDTH'(0);
            phase_q      <= PER_WIDTH'(0);
            per_q        <= MIN_PER;
            cap_out_q    <= 1'b0;
            tooth_num_q  <= TN_WIDTH'(0);
            gap_q        <= 1'b0;
            rev_strobe_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            phase_q      <= phase_d;
            per_q        <= per_d;
            cap_out_q    <= cap_out_d;
            tooth_num_q  <= tooth_num_d;
            gap_q        <= gap_d;
            rev_strobe_q <= rev_strobe_d;
            running_q    <= running_d;
        end
    end

    assign cap_out    = cap_out_q;
    assign tooth_num  = tooth_num_q;
    assign gap        = gap_q;
    assign rev_strobe = rev_strobe_q;
    assign running    = running_q;

endmodule
